pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Next-generation PC unit: owns the architectural fetch PC register instead of a bare next-PC mux.
//  - Sequential advance; execute-stage branch/JAL/JALR redirects; fetch-stall hold with pending-redirect latch.
//  - Trap redirect; misaligned-target fault detection. Sits between execute (resolution) and fetch (pc out).
// PARAMETERS
//  XLEN        32            data/address width
//  RESET_PC    32'h0000_0000 PC loaded on reset
//  ALIGN_BITS  2             target must have ALIGN_BITS LSBs zero (2 = 4-byte insns, 1 = compressed)
//  INSN_BYTES  4             sequential increment
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     asynchronous, active-high reset
//  stall         in   1     fetch not ready: hold pc
//  res_valid     in   1     execute presents a resolved control-flow insn this cycle
//  branchjump    in   2     00 seq, 01 branch, 10 JAL, 11 JALR (valid with res_valid)
//  flag          in   1     branch condition true (used only for 01)
//  res_pc        in   XLEN  PC of the resolving insn
//  imm           in   XLEN  sign-extended immediate
//  rs1           in   XLEN  JALR base register value
//  trap_valid    in   1     take trap this cycle
//  trap_vec      in   XLEN  trap target
//  pc            out  XLEN  current fetch PC
//  pc_valid      out  1     pc is a legal fetch address
//  flush         out  1     1-cycle pulse: younger in-flight insns must be squashed
//  misalign      out  1     1-cycle pulse: redirect target misaligned
//  misalign_addr out  XLEN  offending target, held until next misalign or reset
// BEHAVIOUR
//  Reset (async, any state): pc=RESET_PC, pc_valid=1 after the first rising clk with rst=0 (0 while rst=1), flush=0,
//   misalign=0, misalign_addr=0, state=RUN, pending cleared. Reset mid-HOLD/FAULT discards pending target.
//  Targets: br/JAL = res_pc+imm; JALR = (rs1+imm) & ~1. All adds mod 2^XLEN (wrap, no carry out).
//  Redirect request: res_valid & (bj==10 | bj==11 | (bj==01 & flag)). bj==00, or 01 with flag=0 -> no redirect, no flush.
//  Misaligned: target[ALIGN_BITS-1:0]!=0 on a redirect request -> misalign=1 next cycle, misalign_addr=target,
//   flush=1, pc held, state->FAULT.
//  State RUN:
//   - priority trap > redirect > stall > sequential
//   - trap_valid: pc<=trap_vec, flush=1 next cycle
//   - aligned redirect, stall=0: pc<=target next cycle (latency 1), flush=1
//   - aligned redirect, stall=1: pend<=target, flush=1, pc held, ->HOLD
//   - stall=1: pc held
//   - else pc<=pc+INSN_BYTES
//  State HOLD:
//   - pc held while stall=1
//   - stall=0: pc<=pend next cycle, ->RUN
//   - new aligned redirect in HOLD overwrites pend (flush again); misaligned one ->FAULT
//   - trap_valid: pc<=trap_vec, ->RUN
//  State FAULT: pc_valid=0, pc held, redirects/stall ignored; only trap_valid leaves (pc<=trap_vec, pc_valid=1 next cycle, ->RUN).
//  trap_valid wins over a same-cycle redirect (redirect dropped, no misalign).
//  flush, misalign are registered single-cycle pulses; never asserted during reset.
// TESTING
//  1 reset RESET_PC=0x100, release, 3 clk no stall -> pc 0x100,0x104,0x108; pc_valid=1 from first post-reset edge.
//  2 res_valid bj=01 flag=1 res_pc=0x200 imm=0x40 -> next pc=0x240, flush=1 one cycle; flag=0 -> pc+4, flush=0.
//  3 JALR rs1=0x1001 imm=0x2, stall=1 for 3 cycles -> pc held, flush=1 once; stall drops -> next pc=0x1002? no: ALIGN_BITS=2 ->
//    misalign=1, misalign_addr=0x1002, pc_valid=0; then trap_valid trap_vec=0x80 -> pc=0x80, pc_valid=1.
//  4 JAL res_pc=0x300 imm=0x10 while stall=1, then stall=0 -> pc=0x310 one cycle after stall drops.
//  5 trap_valid + JAL same cycle, trap_vec=0x80 -> pc=0x80, no misalign; pc=0xFFFF_FFFC seq -> 0x0 wrap.
//  6 assert rst during HOLD -> pc=RESET_PC immediately, pending discarded after release.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: owns the architectural fetch PC.
// It advances the PC sequentially and takes branch/JAL/JALR redirects resolved in execute.
// While fetch is stalled it holds the PC and latches a pending redirect target.
// It also takes trap redirects and detects misaligned redirect targets.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   stall           fetch not ready: hold pc
//   res_valid       execute presents a resolved control-flow insn
//   branchjump      00 seq, 01 branch, 10 JAL, 11 JALR
//   flag            branch condition (only for 01)
//   res_pc/imm/rs1  operands used to form the redirect target
//   trap_valid      take trap this cycle, target trap_vec
//   pc, pc_valid    current fetch PC and its legality
//   flush           1-cycle pulse: squash younger in-flight insns
//   misalign        1-cycle pulse: redirect target misaligned
//   misalign_addr   last misaligned target, held until next misalign or reset
module pc_gen #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     ALIGN_BITS = 2,
    parameter int unsigned     INSN_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            res_valid,
    input  logic [1:0]      branchjump,
    input  logic            flag,
    input  logic [XLEN-1:0] res_pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            flush,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr
);

    typedef enum logic [1:0] {StRun, StHold, StFault} state_e;

    state_e          state;
    logic [XLEN-1:0] pend;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] align_mask;
    logic            redirect;
    logic            misaligned;

    always_comb begin
        align_mask = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
        if (branchjump == 2'b11) begin
            target = (rs1 + imm) & ~XLEN'(1);
        end else begin
            target = res_pc + imm;
        end
        redirect   = res_valid & (branchjump[1] | (branchjump == 2'b01 & flag));
        misaligned = |(target & align_mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StRun;
            pc            <= RESET_PC;
            pend          <= '0;
            pc_valid      <= 1'b0;
            flush         <= 1'b0;
            misalign      <= 1'b0;
            misalign_addr <= '0;
        end else begin
            flush    <= 1'b0;
            misalign <= 1'b0;
            pc_valid <= 1'b1;
            if (trap_valid) begin
                // Trap beats any same-cycle redirect; the redirect is dropped entirely.
                pc    <= trap_vec;
                flush <= 1'b1;
                state <= StRun;
            end else begin
                case (state)
                    StRun, StHold: begin
                        if (redirect && misaligned) begin
                            misalign      <= 1'b1;
                            misalign_addr <= target;
                            flush         <= 1'b1;
                            pc_valid      <= 1'b0;
                            state         <= StFault;
                        end else if (redirect) begin
                            flush <= 1'b1;
                            if (stall) begin
                                pend  <= target;
                                state <= StHold;
                            end else begin
                                pc    <= target;
                                state <= StRun;
                            end
                        end else if (!stall) begin
                            if (state == StHold) begin
                                pc    <= pend;
                                state <= StRun;
                            end else if (pc_valid) begin
                                // First edge after reset only validates RESET_PC.
                                pc <= pc + XLEN'(INSN_BYTES);
                            end
                        end
                    end
                    StFault: begin
                        pc_valid <= 1'b0;
                    end
                    default: begin
                        state <= StRun;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with RESET_PC = 0x100 and 4-byte aligned instructions.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        res_valid;
    logic [1:0]  branchjump;
    logic        flag;
    logic [31:0] res_pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        misalign;
    logic [31:0] misalign_addr;

    int n_assert = 0;
    int n_fail   = 0;

    pc_gen #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0100),
        .ALIGN_BITS(2),
        .INSN_BYTES(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .res_valid    (res_valid),
        .branchjump   (branchjump),
        .flag         (flag),
        .res_pc       (res_pc),
        .imm          (imm),
        .rs1          (rs1),
        .trap_valid   (trap_valid),
        .trap_vec     (trap_vec),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .flush        (flush),
        .misalign     (misalign),
        .misalign_addr(misalign_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_pc, input logic e_valid,
                           input logic e_flush, input logic e_mis);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".pc_valid"}, {31'b0, pc_valid}, {31'b0, e_valid});
        chk({tag, ".flush"}, {31'b0, flush}, {31'b0, e_flush});
        chk({tag, ".misalign"}, {31'b0, misalign}, {31'b0, e_mis});
    endtask

    task automatic resolve(input logic [1:0] bj, input logic f, input logic [31:0] rpc,
                           input logic [31:0] im, input logic [31:0] r1);
        res_valid  = 1'b1;
        branchjump = bj;
        flag       = f;
        res_pc     = rpc;
        imm        = im;
        rs1        = r1;
    endtask

    initial begin
        rst        = 1'b1;
        stall      = 1'b0;
        res_valid  = 1'b0;
        branchjump = 2'b00;
        flag       = 1'b0;
        res_pc     = '0;
        imm        = '0;
        rs1        = '0;
        trap_valid = 1'b0;
        trap_vec   = '0;

        // 1: reset and sequential advance
        step();
        step();
        chk_out("reset", 32'h100, 1'b0, 1'b0, 1'b0);
        chk("reset.misalign_addr", misalign_addr, 32'h0);
        rst = 1'b0;
        step();
        chk_out("seq0", 32'h100, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("seq1", 32'h104, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("seq2", 32'h108, 1'b1, 1'b0, 1'b0);

        // 2: taken branch, then not-taken branch
        resolve(2'b01, 1'b1, 32'h200, 32'h40, 32'h0);
        step();
        chk_out("br_taken", 32'h240, 1'b1, 1'b1, 1'b0);
        res_valid = 1'b0;
        step();
        chk_out("br_after", 32'h244, 1'b1, 1'b0, 1'b0);
        resolve(2'b01, 1'b0, 32'h200, 32'h40, 32'h0);
        step();
        chk_out("br_not_taken", 32'h248, 1'b1, 1'b0, 1'b0);
        res_valid = 1'b0;

        // 4: JAL while stalled goes to HOLD, applied one cycle after stall drops
        stall = 1'b1;
        resolve(2'b10, 1'b0, 32'h300, 32'h10, 32'h0);
        step();
        chk_out("jal_hold0", 32'h248, 1'b1, 1'b1, 1'b0);
        res_valid = 1'b0;
        step();
        chk_out("jal_hold1", 32'h248, 1'b1, 1'b0, 1'b0);
        stall = 1'b0;
        step();
        chk_out("jal_release", 32'h310, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("jal_seq", 32'h314, 1'b1, 1'b0, 1'b0);

        // 3: misaligned JALR -> FAULT, only a trap leaves
        stall = 1'b1;
        resolve(2'b11, 1'b0, 32'h0, 32'h2, 32'h1001);
        step();
        chk_out("jalr_mis", 32'h314, 1'b0, 1'b1, 1'b1);
        chk("jalr_mis.addr", misalign_addr, 32'h1002);
        res_valid = 1'b0;
        step();
        chk_out("fault_hold", 32'h314, 1'b0, 1'b0, 1'b0);
        stall = 1'b0;
        resolve(2'b10, 1'b0, 32'h300, 32'h10, 32'h0);
        step();
        chk_out("fault_ignore", 32'h314, 1'b0, 1'b0, 1'b0);
        res_valid  = 1'b0;
        trap_valid = 1'b1;
        trap_vec   = 32'h80;
        step();
        chk_out("fault_trap", 32'h80, 1'b1, 1'b1, 1'b0);
        chk("fault_trap.addr", misalign_addr, 32'h1002);
        trap_valid = 1'b0;
        step();
        chk_out("fault_trap_seq", 32'h84, 1'b1, 1'b0, 1'b0);

        // 5: trap beats a same-cycle misaligned JAL; wraparound
        resolve(2'b10, 1'b0, 32'h300, 32'h2, 32'h0);
        trap_valid = 1'b1;
        trap_vec   = 32'h80;
        step();
        chk_out("trap_vs_jal", 32'h80, 1'b1, 1'b1, 1'b0);
        res_valid = 1'b0;
        trap_vec  = 32'hFFFF_FFFC;
        step();
        chk_out("trap_top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
        trap_valid = 1'b0;
        step();
        chk_out("wrap", 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("wrap_seq", 32'h4, 1'b1, 1'b0, 1'b0);

        // 6: reset during HOLD discards the pending target
        stall = 1'b1;
        resolve(2'b10, 1'b0, 32'h300, 32'h10, 32'h0);
        step();
        chk_out("hold_pre_rst", 32'h4, 1'b1, 1'b1, 1'b0);
        res_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 32'h100, 1'b0, 1'b0, 1'b0);
        step();
        stall = 1'b0;
        rst   = 1'b0;
        step();
        chk_out("rst_release", 32'h100, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("rst_no_pend", 32'h104, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
